// File: rtl/cpu_pkg.sv
// Shared encodings for the phase sequencer: phase codes, instruction class,
// function and branch field values, and the decoded-class bundle.
package cpu_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_P1   = 3'd1,
    PH_P2   = 3'd2,
    PH_P3   = 3'd3,
    PH_P4   = 3'd4,
    PH_P5   = 3'd5,
    PH_HALT = 3'd7
  } phase_t;

  localparam logic [1:0] CLS_LD  = 2'b00;
  localparam logic [1:0] CLS_ST  = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_ALU = 2'b11;

  localparam logic [3:0] FN_OUT = 4'b1101;
  localparam logic [3:0] FN_HLT = 4'b1111;

  localparam logic [2:0] BR_B   = 3'b100;
  localparam logic [2:0] BR_BCC = 3'b111;

  typedef struct packed {
    logic is_ld;
    logic is_st;
    logic is_br_u;
    logic is_br_c;
    logic is_out;
    logic is_hlt;
  } iclass_t;

  function automatic logic [1:0] get_cls(input logic [15:0] word);
    return word[15:14];
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational classification of the latched instruction word into the
// handful of flags the phase sequencer steers on.
module instr_class_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output iclass_t     iclass
);

  logic [1:0] cls;
  logic       unused_bits;

  assign cls = get_cls(ir);
  // Register/immediate fields matter only to the datapath decoder.
  assign unused_bits = ^{ir[10:8], ir[3:0]};

  always_comb begin
    iclass         = '0;
    iclass.is_ld   = (cls == CLS_LD);
    iclass.is_st   = (cls == CLS_ST);
    iclass.is_br_u = (cls == CLS_BR)  && (ir[13:11] == BR_B);
    iclass.is_br_c = (cls == CLS_BR)  && (ir[13:11] == BR_BCC);
    iclass.is_out  = (cls == CLS_ALU) && (ir[7:4] == FN_OUT);
    iclass.is_hlt  = (cls == CLS_ALU) && (ir[7:4] == FN_HLT);
  end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle phase controller: walks each instruction through fetch, decode,
// execute, memory and writeback and issues the phase-qualified strobes.
module phase_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter bit SKIP_MEM = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_ready,
  input  logic             write_order,
  input  logic             branch_taken,
  output logic [15:0]      ir,
  output logic [2:0]       phase,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel_branch,
  output logic             mem_re,
  output logic             mem_we,
  output logic             reg_we,
  output logic             out_we,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  phase_t           phase_reg;
  logic [15:0]      ir_reg;
  logic [CNT_W-1:0] instr_count_reg;
  iclass_t          iclass;
  logic             take_branch;

  instr_class_decode u_decode (
    .ir     (ir_reg),
    .iclass (iclass)
  );

  assign take_branch = iclass.is_br_u | (iclass.is_br_c & branch_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg       <= PH_IDLE;
      ir_reg          <= '0;
      instr_count_reg <= '0;
    end else begin
      case (phase_reg)
        PH_IDLE: if (run) phase_reg <= PH_P1;
        PH_P1: begin
          if (mem_ready) begin
            ir_reg    <= mem_rdata;
            phase_reg <= PH_P2;
          end
        end
        PH_P2: phase_reg <= PH_P3;
        PH_P3: begin
          if (iclass.is_hlt)
            phase_reg <= PH_HALT;
          else if (iclass.is_ld || iclass.is_st || !SKIP_MEM)
            phase_reg <= PH_P4;
          else
            phase_reg <= PH_P5;
        end
        PH_P4: begin
          // Only real memory accesses stall on the handshake.
          if (!(iclass.is_ld || iclass.is_st) || mem_ready)
            phase_reg <= PH_P5;
        end
        PH_P5: begin
          instr_count_reg <= instr_count_reg + CNT_ONE;
          phase_reg       <= run ? PH_P1 : PH_IDLE;
        end
        PH_HALT: phase_reg <= PH_HALT;
        default: phase_reg <= PH_IDLE;
      endcase
    end
  end

  // Strobes are suppressed during the reset cycle so an aborted instruction
  // leaves no side effect behind.
  always_comb begin
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel_branch = 1'b0;
    mem_re        = 1'b0;
    mem_we        = 1'b0;
    reg_we        = 1'b0;
    out_we        = 1'b0;
    if (!rst) begin
      case (phase_reg)
        PH_P1: begin
          mem_re = 1'b1;
          ir_we  = mem_ready;
          pc_we  = mem_ready;
        end
        PH_P4: begin
          mem_re = iclass.is_ld;
          mem_we = iclass.is_st;
        end
        PH_P5: begin
          reg_we        = write_order & ~iclass.is_st;
          out_we        = iclass.is_out;
          pc_we         = take_branch;
          pc_sel_branch = take_branch;
        end
        default: ;
      endcase
    end
  end

  assign ir          = ir_reg;
  assign phase       = phase_reg;
  assign halted      = (phase_reg == PH_HALT) && !rst;
  assign instr_count = instr_count_reg;

endmodule
